// File: rtl/ps2_typewriter_keyboard.sv
// PS/2 keyboard receiver and scan-code decoder feeding a 4-entry typewriter character FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a start bit (ps2_data=0 on a filtered clk fall)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | sampling the parity bit; a parity error is remembered
// S_STOP   | sampling the stop bit; releases the byte or flags an error
module ps2_typewriter_keyboard #(
    parameter int CLK_HZ     = 75000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [6:0] char_out,
    output logic       char_valid,
    input  logic       char_ack,
    output logic       shift_active,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic       frame_error
);

    localparam longint unsigned TO_CYC = (64'(CLK_HZ) * 64'(TIMEOUT_US)) / 64'd1000000;
    localparam int TO_W  = $clog2(TO_CYC + 1);
    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic             clk_filt_q, clk_filt_d;
    logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic             clk_fall;
    rx_state_t        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_err_q, par_err_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic             frame_error_q, frame_error_d;
    logic             byte_rdy;
    logic             brk_q, brk_d, ext_q, ext_d, shl_q, shl_d, shr_q, shr_d;
    logic [6:0]       dec_char_q, dec_char_d;
    logic             dec_vld_q, dec_vld_d;
    logic [13:0]      lut;
    logic [6:0]       mem_q [4];
    logic [6:0]       mem_d [4];
    logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop, push_ok;

    // Scan code to {unshifted, shifted} ASCII; zero means unmapped.
    function automatic logic [13:0] kbd_map(input logic [7:0] code);
        case (code)
            8'h1C: kbd_map = {7'h61, 7'h41};   8'h32: kbd_map = {7'h62, 7'h42};
            8'h21: kbd_map = {7'h63, 7'h43};   8'h23: kbd_map = {7'h64, 7'h44};
            8'h24: kbd_map = {7'h65, 7'h45};   8'h2B: kbd_map = {7'h66, 7'h46};
            8'h34: kbd_map = {7'h67, 7'h47};   8'h33: kbd_map = {7'h68, 7'h48};
            8'h43: kbd_map = {7'h69, 7'h49};   8'h3B: kbd_map = {7'h6A, 7'h4A};
            8'h42: kbd_map = {7'h6B, 7'h4B};   8'h4B: kbd_map = {7'h6C, 7'h4C};
            8'h3A: kbd_map = {7'h6D, 7'h4D};   8'h31: kbd_map = {7'h6E, 7'h4E};
            8'h44: kbd_map = {7'h6F, 7'h4F};   8'h4D: kbd_map = {7'h70, 7'h50};
            8'h15: kbd_map = {7'h71, 7'h51};   8'h2D: kbd_map = {7'h72, 7'h52};
            8'h1B: kbd_map = {7'h73, 7'h53};   8'h2C: kbd_map = {7'h74, 7'h54};
            8'h3C: kbd_map = {7'h75, 7'h55};   8'h2A: kbd_map = {7'h76, 7'h56};
            8'h1D: kbd_map = {7'h77, 7'h57};   8'h22: kbd_map = {7'h78, 7'h58};
            8'h35: kbd_map = {7'h79, 7'h59};   8'h1A: kbd_map = {7'h7A, 7'h5A};
            8'h45: kbd_map = {7'h30, 7'h29};   8'h16: kbd_map = {7'h31, 7'h21};
            8'h1E: kbd_map = {7'h32, 7'h40};   8'h26: kbd_map = {7'h33, 7'h23};
            8'h25: kbd_map = {7'h34, 7'h24};   8'h2E: kbd_map = {7'h35, 7'h25};
            8'h36: kbd_map = {7'h36, 7'h5E};   8'h3D: kbd_map = {7'h37, 7'h26};
            8'h3E: kbd_map = {7'h38, 7'h2A};   8'h46: kbd_map = {7'h39, 7'h28};
            8'h29: kbd_map = {7'h20, 7'h20};   8'h5A: kbd_map = {7'h0D, 7'h0D};
            8'h66: kbd_map = {7'h08, 7'h08};   8'h4E: kbd_map = {7'h2D, 7'h5F};
            8'h49: kbd_map = {7'h2E, 7'h3E};   8'h41: kbd_map = {7'h2C, 7'h3C};
            default: kbd_map = '0;
        endcase
    endfunction

    // Two-flop synchronizers; lines reset to their idle-high level so no false edge follows reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1_q <= 1'b1; clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1; dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;  clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data; dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: ps2_clk changes level only after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == CNT_W'(FILTER_LEN - 1)) clk_filt_d = clk_s2_q;
            else                                      filt_cnt_d = filt_cnt_q + CNT_W'(1);
        end
    end

    assign clk_fall = clk_filt_q & ~clk_filt_d;

    // Frame receiver with a down-counting frame timeout that only runs outside S_IDLE.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        par_err_d     = par_err_q;
        timer_d       = timer_q;
        byte_rdy      = 1'b0;
        frame_error_d = 1'b0;
        if (state_q == S_IDLE) timer_d = TO_W'(TO_CYC);
        if (state_q != S_IDLE && timer_q == '0) begin
            state_d       = S_IDLE;
            frame_error_d = 1'b1;
        end else begin
            if (state_q != S_IDLE) timer_d = timer_q - TO_W'(1);
            if (clk_fall) begin
                unique case (state_q)
                    S_IDLE: if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                    S_DATA: begin
                        shreg_d   = {dat_s2_q, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                    end
                    S_PARITY: begin
                        par_err_d = ~(^shreg_q ^ dat_s2_q);
                        state_d   = S_STOP;
                    end
                    S_STOP: begin
                        if (dat_s2_q && !par_err_q) byte_rdy      = 1'b1;
                        else                        frame_error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Scan decoder: prefix flags, shift tracking and character lookup into the decode register.
    always_comb begin
        brk_d      = brk_q;
        ext_d      = ext_q;
        shl_d      = shl_q;
        shr_d      = shr_q;
        dec_char_d = dec_char_q;
        dec_vld_d  = 1'b0;
        lut        = kbd_map(shreg_q);
        if (byte_rdy) begin
            if (shreg_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shreg_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (!ext_q) begin
                    if (shreg_q == 8'h12)      shl_d = ~brk_q;
                    else if (shreg_q == 8'h59) shr_d = ~brk_q;
                    else if (!brk_q && lut[13:7] != '0) begin
                        dec_char_d = shift_active ? lut[6:0] : lut[13:7];
                        dec_vld_d  = 1'b1;
                    end
                end
            end
        end
    end

    // Character FIFO; a push into a full FIFO only succeeds when the head is popped in the same cycle.
    always_comb begin
        pop        = char_ack && (count_q != 3'd0);
        push_ok    = dec_vld_q && (count_q != 3'd4 || pop);
        mem_d      = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = dec_char_q;
        wr_ptr_d   = wr_ptr_q + {1'b0, push_ok};
        rd_ptr_d   = rd_ptr_q + {1'b0, pop};
        count_d    = count_q + {2'b0, push_ok} - {2'b0, pop};
        overflow_d = overflow_q;
        if (overflow_clr)           overflow_d = 1'b0;
        if (dec_vld_q && !push_ok)  overflow_d = 1'b1;
    end

    // State registers for filter, receiver, decoder and FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt_q    <= 1'b1;
            filt_cnt_q    <= '0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            par_err_q     <= 1'b0;
            timer_q       <= TO_W'(TO_CYC);
            frame_error_q <= 1'b0;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            shl_q         <= 1'b0;
            shr_q         <= 1'b0;
            dec_char_q    <= '0;
            dec_vld_q     <= 1'b0;
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
        end else begin
            clk_filt_q    <= clk_filt_d;
            filt_cnt_q    <= filt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            par_err_q     <= par_err_d;
            timer_q       <= timer_d;
            frame_error_q <= frame_error_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            shl_q         <= shl_d;
            shr_q         <= shr_d;
            dec_char_q    <= dec_char_d;
            dec_vld_q     <= dec_vld_d;
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign char_out     = mem_q[rd_ptr_q];
    assign char_valid   = (count_q != 3'd0);
    assign shift_active = shl_q | shr_q;
    assign overflow     = overflow_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_ps2_typewriter_keyboard.sv
// Bench for ps2_typewriter_keyboard: PS/2 frame driver, keyboard reference model and character scoreboard.
module tb_ps2_typewriter_keyboard;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [6:0] char_out;
    logic       char_valid;
    logic       char_ack = 1'b0;
    logic       shift_active;
    logic       overflow;
    logic       overflow_clr = 1'b0;
    logic       frame_error;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;

    logic [6:0] exp_q[$];
    bit m_brk, m_ext, m_shl, m_shr, m_ovf;

    logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    ps2_typewriter_keyboard #(.CLK_HZ(1000000), .FILTER_LEN(8), .TIMEOUT_US(1000)) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .char_out(char_out), .char_valid(char_valid), .char_ack(char_ack),
        .shift_active(shift_active), .overflow(overflow), .overflow_clr(overflow_clr),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_error === 1'b1) fe_cnt++;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference keymap: returns -1 for codes that produce no character.
    function automatic int bench_map(input logic [7:0] code, input bit sh);
        string dsh = ")!@#$%^&*(";
        for (int i = 0; i < 26; i++) if (code == letter_sc[i]) return sh ? 65 + i : 97 + i;
        for (int i = 0; i < 10; i++) if (code == digit_sc[i]) return sh ? int'(dsh[i]) : 48 + i;
        case (code)
            8'h29: return 32;
            8'h5A: return 13;
            8'h66: return 8;
            8'h4E: return sh ? 95 : 45;
            8'h49: return sh ? 62 : 46;
            8'h41: return sh ? 60 : 44;
            default: return -1;
        endcase
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (15) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit par_ok, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par_ok ? ~^code : ^code);
        ps2_bit(stop);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Sends a valid frame and advances the keyboard model, queueing any expected character.
    task automatic send_key(input logic [7:0] code);
        int c;
        send_frame(code, 1'b1, 1'b1);
        if (code == 8'hF0) m_brk = 1'b1;
        else if (code == 8'hE0) m_ext = 1'b1;
        else begin
            if (!m_ext) begin
                if (code == 8'h12) m_shl = !m_brk;
                else if (code == 8'h59) m_shr = !m_brk;
                else if (!m_brk) begin
                    c = bench_map(code, m_shl | m_shr);
                    if (c >= 0) begin
                        if (exp_q.size() < 4) exp_q.push_back(7'(c));
                        else m_ovf = 1'b1;
                    end
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    // Waits (bounded) for a character, reports it and acknowledges it.
    task automatic pop_char(output logic [6:0] got, output bit seen);
        for (int i = 0; i < 60 && char_valid !== 1'b1; i++) @(negedge clk);
        seen = (char_valid === 1'b1);
        got  = char_out;
        if (seen) begin
            char_ack = 1'b1;
            @(negedge clk);
            char_ack = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (char_out !== 7'h00) begin bad++; $display("FAIL reset_char_out: got %h want 00", char_out); end
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL reset_char_valid: got %b want 0", char_valid); end
        total++; if (shift_active !== 1'b0) begin bad++; $display("FAIL reset_shift: got %b want 0", shift_active); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_frame_error: got %b want 0", frame_error); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [6:0] got, e;
        bit seen;
        send_key(8'h1C);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_char(got, seen);
            total++; if (!seen || got !== e) begin bad++; $display("FAIL basic_char: got %h valid %b want %h", got, seen, e); end
        end
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL basic_empty: char_valid %b want 0", char_valid); end
    endtask

    task automatic test_shift();
        logic [6:0] got, e;
        bit seen;
        send_key(8'h12);
        total++; if (shift_active !== m_shl) begin bad++; $display("FAIL shift_held: got %b want %b", shift_active, m_shl); end
        send_key(8'h1C);
        send_key(8'hF0); send_key(8'h1C);
        send_key(8'hF0); send_key(8'h12);
        total++; if (shift_active !== (m_shl | m_shr)) begin bad++; $display("FAIL shift_released: got %b want 0", shift_active); end
        send_key(8'h1C);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_char(got, seen);
            total++; if (!seen || got !== e) begin bad++; $display("FAIL shift_char: got %h valid %b want %h", got, seen, e); end
        end
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL shift_empty: char_valid %b want 0", char_valid); end
    endtask

    task automatic test_overflow();
        logic [6:0] got, e;
        bit seen;
        logic [7:0] codes [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
        m_ovf = 1'b0;
        foreach (codes[i]) send_key(codes[i]);
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL overflow_set: got %b want %b", overflow, m_ovf); end
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        m_ovf = 1'b0;
        total++; if (overflow !== m_ovf) begin bad++; $display("FAIL overflow_clr: got %b want 0", overflow); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_char(got, seen);
            total++; if (!seen || got !== e) begin bad++; $display("FAIL overflow_char: got %h valid %b want %h", got, seen, e); end
        end
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL overflow_empty: char_valid %b want 0", char_valid); end
    endtask

    task automatic test_frame_errors();
        logic [6:0] got, e;
        bit seen;
        fe_cnt = 0;
        send_frame(8'h1C, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b0);
        total++; if (fe_cnt != 2) begin bad++; $display("FAIL frame_error_count: got %0d want 2", fe_cnt); end
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL error_no_char: char_valid %b want 0", char_valid); end
        send_key(8'h29);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_char(got, seen);
            total++; if (!seen || got !== e) begin bad++; $display("FAIL error_recover_char: got %h valid %b want %h", got, seen, e); end
        end
    endtask

    task automatic test_timeout_glitch();
        logic [6:0] got, e;
        bit seen;
        fe_cnt = 0;
        ps2_bit(1'b0);
        ps2_data = 1'b1;
        repeat (1100) @(negedge clk);
        total++; if (fe_cnt != 1) begin bad++; $display("FAIL timeout_pulse: got %0d pulses want 1", fe_cnt); end
        send_key(8'h4E);
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk);
        send_key(8'h49);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_char(got, seen);
            total++; if (!seen || got !== e) begin bad++; $display("FAIL timeout_glitch_char: got %h valid %b want %h", got, seen, e); end
        end
        total++; if (fe_cnt != 1) begin bad++; $display("FAIL glitch_no_error: got %0d pulses want 1", fe_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] got, e;
        bit seen;
        send_key(8'h1C);
        send_key(8'h1C);
        send_key(8'h4D);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_char(got, seen);
            total++; if (!seen || got !== e) begin bad++; $display("FAIL repeat_char: got %h valid %b want %h", got, seen, e); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] got, e;
        bit seen;
        send_key(8'h59);
        send_key(8'h15); send_key(8'h1D); send_key(8'h24);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (char_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b want 0", char_valid); end
        total++; if (char_out !== 7'h00) begin bad++; $display("FAIL midreset_char_out: got %h want 00", char_out); end
        total++; if (shift_active !== 1'b0) begin bad++; $display("FAIL midreset_shift: got %b want 0", shift_active); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midreset_overflow: got %b want 0", overflow); end
        total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL midreset_frame_error: got %b want 0", frame_error); end
        exp_q.delete();
        m_brk = 1'b0; m_ext = 1'b0; m_shl = 1'b0; m_shr = 1'b0; m_ovf = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send_key(8'h5A);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            pop_char(got, seen);
            total++; if (!seen || got !== e) begin bad++; $display("FAIL midreset_recover_char: got %h valid %b want %h", got, seen, e); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_overflow();
        test_frame_errors();
        test_timeout_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
